// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : shares the data memory between the CPU MEM stage and a DMA port
// rev 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int WORD_LENGTH = 8,
   parameter int ADDR_LENGTH = 8,
   parameter int MEM_LATENCY = 2,
   parameter int MAX_CPU_RUN = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_mem_read,
   input  logic                   cpu_mem_write,
   input  logic [ADDR_LENGTH-1:0] cpu_addr,
   input  logic [WORD_LENGTH-1:0] cpu_wdata,
   output logic [WORD_LENGTH-1:0] cpu_rdata,
   output logic                   cpu_stall,
   input  logic                   dma_req,
   input  logic                   dma_we,
   input  logic [ADDR_LENGTH-1:0] dma_addr,
   input  logic [WORD_LENGTH-1:0] dma_wdata,
   output logic [WORD_LENGTH-1:0] dma_rdata,
   output logic                   dma_ack,
   output logic [ADDR_LENGTH-1:0] mem_addr,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   output logic                   mem_read,
   output logic                   mem_write,
   input  logic [WORD_LENGTH-1:0] mem_rdata,
   output logic [1:0]             owner
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [1:0] c_OWN_NONE = 2'b00;
   localparam logic [1:0] c_OWN_CPU  = 2'b01;
   localparam logic [1:0] c_OWN_DMA  = 2'b10;
   localparam logic [3:0] c_LAT_INIT = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] c_MAX_RUN  = 4'(MAX_CPU_RUN);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [3:0]             r_lat_cnt;
   logic [3:0]             r_cpu_streak;
   logic [ADDR_LENGTH-1:0] r_addr;
   logic [WORD_LENGTH-1:0] r_wdata;
   logic                   r_we;
   logic [1:0]             r_owner;
   logic [WORD_LENGTH-1:0] r_cpu_rdata;
   logic [WORD_LENGTH-1:0] r_dma_rdata;

   logic w_cpu_req;
   logic w_grant_dma;
   logic w_grant_cpu;

   assign w_cpu_req   = cpu_mem_read | cpu_mem_write;
   // DMA wins an idle memory, or a contended one once the CPU has used up its run.
   assign w_grant_dma = dma_req & (~w_cpu_req | (r_cpu_streak == c_MAX_RUN));
   assign w_grant_cpu = w_cpu_req & ~w_grant_dma;

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign owner     = r_owner;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;
   assign cpu_stall = w_cpu_req & ~((r_state == S_DONE) & (r_owner == c_OWN_CPU));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      dma_ack      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_dma | w_grant_cpu) begin
               w_state_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_read  = ~r_we;
            mem_write = r_we;
            if (r_lat_cnt == 4'd0) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            dma_ack      = (r_owner == c_OWN_DMA);
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lat_cnt    <= 4'd0;
         r_cpu_streak <= 4'd0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_owner      <= c_OWN_NONE;
         r_cpu_rdata  <= '0;
         r_dma_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_dma) begin
                  r_addr       <= dma_addr;
                  r_wdata      <= dma_wdata;
                  r_we         <= dma_we;
                  r_owner      <= c_OWN_DMA;
                  r_lat_cnt    <= c_LAT_INIT;
                  r_cpu_streak <= 4'd0;
               end else if (w_grant_cpu) begin
                  r_addr    <= cpu_addr;
                  r_wdata   <= cpu_wdata;
                  r_we      <= cpu_mem_write;
                  r_owner   <= c_OWN_CPU;
                  r_lat_cnt <= c_LAT_INIT;
                  if (!dma_req) begin
                     r_cpu_streak <= 4'd0;
                  end else if (r_cpu_streak != 4'hF) begin
                     r_cpu_streak <= r_cpu_streak + 4'd1;
                  end
               end
            end
            S_ACCESS: begin
               if (r_lat_cnt == 4'd0) begin
                  if (!r_we && (r_owner == c_OWN_CPU)) begin
                     r_cpu_rdata <= mem_rdata;
                  end
                  if (!r_we && (r_owner == c_OWN_DMA)) begin
                     r_dma_rdata <= mem_rdata;
                  end
               end else begin
                  r_lat_cnt <= r_lat_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_owner <= c_OWN_NONE;
            end
            default: begin
               r_owner <= c_OWN_NONE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cpu_mem_read = 1'b0;
   logic       cpu_mem_write = 1'b0;
   logic [7:0] cpu_addr = 8'h00;
   logic [7:0] cpu_wdata = 8'h00;
   logic [7:0] cpu_rdata;
   logic       cpu_stall;
   logic       dma_req = 1'b0;
   logic       dma_we = 1'b0;
   logic [7:0] dma_addr = 8'h00;
   logic [7:0] dma_wdata = 8'h00;
   logic [7:0] dma_rdata;
   logic       dma_ack;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_rdata = 8'h00;
   logic [1:0] owner;

   int n_vec = 0;
   int n_err = 0;

   dmem_arbiter #(
      .WORD_LENGTH(8),
      .ADDR_LENGTH(8),
      .MEM_LATENCY(2),
      .MAX_CPU_RUN(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starvation scenario expectations, indexed by cycle from the first request.
   logic [1:0] own5   [16] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1,
                               2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
   logic       stall5 [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
      chk("rst_dma_ack", 32'(dma_ack), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      rst = 1'b1;
      tick();

      // 1: reset asserted in the middle of a CPU read
      cpu_mem_read = 1'b1; cpu_addr = 8'h44; mem_rdata = 8'h99;
      #1;
      chk("t1_stall_c0", 32'(cpu_stall), 32'd1);
      tick();
      chk("t1_mem_read_c1", 32'(mem_read), 32'd1);
      rst = 1'b0;
      #1;
      chk("t1_abort_mem_read", 32'(mem_read), 32'd0);
      chk("t1_abort_owner", 32'(owner), 32'd0);
      chk("t1_abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
      cpu_mem_read = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("t1_idle_stall", 32'(cpu_stall), 32'd0);
      chk("t1_idle_mem_read", 32'(mem_read), 32'd0);
      tick();
      chk("t1_idle_owner", 32'(owner), 32'd0);
      chk("t1_no_rdata", 32'(cpu_rdata), 32'd0);

      // 2: CPU read
      cpu_mem_read = 1'b1; cpu_addr = 8'h10; mem_rdata = 8'h5A;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t2_stall_c%0d", c), 32'(cpu_stall), 32'((c < 3) ? 1 : 0));
         chk($sformatf("t2_mem_read_c%0d", c), 32'(mem_read), 32'((c == 1 || c == 2) ? 1 : 0));
         if (c == 1 || c == 2) chk($sformatf("t2_mem_addr_c%0d", c), 32'(mem_addr), 32'h10);
         if (c == 3) begin
            chk("t2_cpu_rdata", 32'(cpu_rdata), 32'h5A);
            cpu_mem_read = 1'b0;
         end
         tick();
      end

      // 3: DMA write alone
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h33;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t3_mem_write_c%0d", c), 32'(mem_write), 32'((c == 1 || c == 2) ? 1 : 0));
         chk($sformatf("t3_dma_ack_c%0d", c), 32'(dma_ack), 32'((c == 3) ? 1 : 0));
         if (c == 1 || c == 2) begin
            chk($sformatf("t3_mem_addr_c%0d", c), 32'(mem_addr), 32'h20);
            chk($sformatf("t3_mem_wdata_c%0d", c), 32'(mem_wdata), 32'h33);
            chk($sformatf("t3_mem_read_c%0d", c), 32'(mem_read), 32'd0);
         end
         if (c == 3) begin
            chk("t3_dma_rdata", 32'(dma_rdata), 32'h00);
            dma_req = 1'b0;
         end
         tick();
      end

      // 4: CPU read and DMA read together, streak 0
      cpu_mem_read = 1'b1; cpu_addr = 8'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h80;
      for (int c = 0; c < 9; c++) begin
         mem_rdata = (c < 3) ? 8'hA5 : ((c == 6) ? 8'hC3 : 8'h11);
         #1;
         if (c == 1 || c == 2) begin
            chk($sformatf("t4_owner_cpu_c%0d", c), 32'(owner), 32'd1);
            chk($sformatf("t4_addr_cpu_c%0d", c), 32'(mem_addr), 32'h40);
         end
         if (c == 5 || c == 6) begin
            chk($sformatf("t4_owner_dma_c%0d", c), 32'(owner), 32'd2);
            chk($sformatf("t4_addr_dma_c%0d", c), 32'(mem_addr), 32'h80);
            chk($sformatf("t4_mem_read_c%0d", c), 32'(mem_read), 32'd1);
         end
         if (c == 4) chk("t4_owner_idle", 32'(owner), 32'd0);
         chk($sformatf("t4_dma_ack_c%0d", c), 32'(dma_ack), 32'((c == 7) ? 1 : 0));
         if (c == 3) begin
            chk("t4_cpu_rdata", 32'(cpu_rdata), 32'hA5);
            chk("t4_cpu_stall_done", 32'(cpu_stall), 32'd0);
            cpu_mem_read = 1'b0;
         end
         if (c == 7) begin
            chk("t4_dma_rdata", 32'(dma_rdata), 32'hC3);
            dma_req = 1'b0;
         end
         tick();
      end

      // 5: CPU continuously requesting while DMA waits
      cpu_mem_read = 1'b1; cpu_addr = 8'h01; mem_rdata = 8'h3C;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h02; dma_wdata = 8'h44;
      for (int c = 0; c < 16; c++) begin
         #1;
         chk($sformatf("t5_owner_c%0d", c), 32'(owner), 32'(own5[c]));
         chk($sformatf("t5_stall_c%0d", c), 32'(cpu_stall), 32'(stall5[c]));
         chk($sformatf("t5_dma_ack_c%0d", c), 32'(dma_ack), 32'((c == 11) ? 1 : 0));
         if (c == 1)  chk("t5_streak_c1", 32'(dut.r_cpu_streak), 32'd1);
         if (c == 5)  chk("t5_streak_c5", 32'(dut.r_cpu_streak), 32'd2);
         if (c == 9)  chk("t5_streak_c9", 32'(dut.r_cpu_streak), 32'd0);
         if (c == 13) chk("t5_streak_c13", 32'(dut.r_cpu_streak), 32'd0);
         if (c == 9 || c == 10) chk($sformatf("t5_dma_write_c%0d", c), 32'(mem_write), 32'd1);
         if (c == 11) dma_req = 1'b0;
         if (c == 15) begin
            chk("t5_cpu_rdata", 32'(cpu_rdata), 32'h3C);
            cpu_mem_read = 1'b0;
         end
         tick();
      end

      // 6: read and write together become a write
      cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'h77;
      mem_rdata = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t6_mem_read_c%0d", c), 32'(mem_read), 32'd0);
         chk($sformatf("t6_mem_write_c%0d", c), 32'(mem_write), 32'((c == 1 || c == 2) ? 1 : 0));
         if (c == 1 || c == 2) begin
            chk($sformatf("t6_addr_c%0d", c), 32'(mem_addr), 32'h05);
            chk($sformatf("t6_wdata_c%0d", c), 32'(mem_wdata), 32'h77);
         end
         if (c == 3) begin
            chk("t6_cpu_rdata_kept", 32'(cpu_rdata), 32'h3C);
            chk("t6_stall_done", 32'(cpu_stall), 32'd0);
            cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
